// File: rtl/ofdm_symbol_framer_if.sv
// ofdm_symbol_framer_if: payload push side plus the Pushin/FirstData/DinR/DinI sample stream.
// master = payload source / sample sink, slave = the framer.
interface ofdm_symbol_framer_if;
    logic                PushIn;
    logic [47:0]         DataIn;
    logic                StopIn;
    logic                Overflow;
    logic                Pushin;
    logic                FirstData;
    logic signed [16:0]  DinR;
    logic signed [16:0]  DinI;

    modport master (
        output PushIn, DataIn,
        input  StopIn, Overflow, Pushin, FirstData, DinR, DinI
    );

    modport slave (
        input  PushIn, DataIn,
        output StopIn, Overflow, Pushin, FirstData, DinR, DinI
    );
endinterface

// File: rtl/ofdm_symbol_framer.sv
// ofdm_symbol_framer: maps each 48-bit payload word onto 24 QPSK carriers of an NBINS-sample symbol.
// Optional macro OFDM_FRAMER_PILOT_EN adds a fixed (+AMP, 0) pilot on bin 2 of every symbol.
module ofdm_symbol_framer #(
    parameter int NBINS      = 128,
    parameter int AMP        = 4096,
    parameter int FIRST_BIN  = 4,
    parameter int BIN_STEP   = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    ofdm_symbol_framer_if.slave  bus
);
    localparam int CW = $clog2(NBINS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [16:0] POS = 17'(AMP);
    localparam logic signed [16:0] NEG = -POS;

`ifdef OFDM_FRAMER_PILOT_EN
    if ((FIRST_BIN <= 2) && (((2 - FIRST_BIN) % BIN_STEP) == 0) &&
        (((2 - FIRST_BIN) / BIN_STEP) <= 23)) begin : g_pilot_collision
        $error("ofdm_symbol_framer: a data carrier lands on pilot bin 2");
    end
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [47:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [NW-1:0]      count;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               pop;

    logic [47:0]        sym;
    logic [CW-1:0]      bin;
    logic               last_bin;
    logic signed [16:0] map_r;
    logic signed [16:0] map_i;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == NW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign wr_en      = bus.PushIn && !full;
    assign bus.StopIn = full;
    assign last_bin   = (bin == CW'(NBINS - 1));

    // Word buffer: a pop in the same cycle never frees a slot for a push.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + NW'(wr_en) - NW'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.DataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = SEND;
            end
            SEND: begin
                if (last_bin) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bin counter runs only in SEND; CW bits wrap naturally after NBINS-1.
    always_ff @(posedge Clk) begin
        if (Reset || (state != SEND)) begin
            bin <= '0;
        end else begin
            bin <= bin + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sym <= '0;
        end else if (pop) begin
            sym <= mem[rd_ptr];
        end
    end

    always_comb begin
        map_r = '0;
        map_i = '0;
        for (int unsigned i = 0; i < 24; i++) begin
            if (32'(bin) == 32'(FIRST_BIN) + i * 32'(BIN_STEP)) begin
                map_r = sym[2*i]     ? NEG : POS;
                map_i = sym[2*i + 1] ? NEG : POS;
            end
        end
`ifdef OFDM_FRAMER_PILOT_EN
        if (bin == CW'(2)) begin
            map_r = POS;
            map_i = '0;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.Overflow  <= 1'b0;
            bus.Pushin    <= 1'b0;
            bus.FirstData <= 1'b0;
            bus.DinR      <= '0;
            bus.DinI      <= '0;
        end else begin
            bus.Overflow  <= bus.PushIn && full;
            bus.Pushin    <= (state == SEND);
            bus.FirstData <= (state == SEND) && (bin == '0);
            bus.DinR      <= (state == SEND) ? map_r : '0;
            bus.DinI      <= (state == SEND) ? map_i : '0;
        end
    end
endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// tb_ofdm_symbol_framer: directed and random pushes checked every cycle against a
// timeline model (word queue, pop cooldown, scheduled symbol start edges).
module tb_ofdm_symbol_framer;
    localparam int NBINS      = 128;
    localparam int AMP        = 4096;
    localparam int FIRST_BIN  = 4;
    localparam int BIN_STEP   = 2;
    localparam int FIFO_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ofdm_symbol_framer_if bus ();

    ofdm_symbol_framer #(
        .NBINS      (NBINS),
        .AMP        (AMP),
        .FIRST_BIN  (FIRST_BIN),
        .BIN_STEP   (BIN_STEP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected sample for one bin of a symbol carrying word w.
    function automatic void ref_bin(input logic [47:0] w, input int b, output int r, output int im);
        int off;
        int idx;
        r   = 0;
        im  = 0;
        off = b - FIRST_BIN;
        if (off >= 0 && (off % BIN_STEP) == 0 && (off / BIN_STEP) < 24) begin
            idx = off / BIN_STEP;
            r   = w[2*idx]     ? -AMP : AMP;
            im  = w[2*idx + 1] ? -AMP : AMP;
        end
`ifdef OFDM_FRAMER_PILOT_EN
        if (b == 2) begin
            r  = AMP;
            im = 0;
        end
`endif
    endfunction

    // Timeline model: a popped word owns output edges pop+2 .. pop+1+NBINS;
    // the next pop may happen NBINS+1 edges after the previous one.
    logic [47:0] q[$];
    longint      edge_n     = 0;
    int          cooldown   = 0;
    bit          cur_v      = 0;
    bit          pend_v     = 0;
    logic [47:0] cur_w      = '0;
    logic [47:0] pend_w     = '0;
    longint      cur_start  = 0;
    longint      pend_start = 0;
    bit          full_pre;
    int          exp_push   = 0;
    int          exp_first  = 0;
    int          exp_r      = 0;
    int          exp_i      = 0;
    int          exp_ovf    = 0;
    int          b;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            q.delete();
            cooldown  = 0;
            cur_v     = 0;
            pend_v    = 0;
            exp_push  = 0;
            exp_first = 0;
            exp_r     = 0;
            exp_i     = 0;
            exp_ovf   = 0;
        end else begin
            full_pre = (q.size() == FIFO_DEPTH);
            if (pend_v && edge_n >= pend_start) begin
                cur_v     = 1;
                cur_w     = pend_w;
                cur_start = pend_start;
                pend_v    = 0;
            end
            if (cur_v && edge_n >= cur_start && edge_n < cur_start + NBINS) begin
                b         = int'(edge_n - cur_start);
                exp_push  = 1;
                exp_first = (b == 0) ? 1 : 0;
                ref_bin(cur_w, b, exp_r, exp_i);
            end else begin
                exp_push  = 0;
                exp_first = 0;
                exp_r     = 0;
                exp_i     = 0;
            end
            exp_ovf = (bus.PushIn && full_pre) ? 1 : 0;
            if (cooldown == 0 && q.size() > 0) begin
                pend_w     = q.pop_front();
                pend_v     = 1;
                pend_start = edge_n + 2;
                cooldown   = NBINS;
            end else if (cooldown > 0) begin
                cooldown--;
            end
            if (bus.PushIn && !full_pre) begin
                q.push_back(bus.DataIn);
            end
        end
    end

    int sym_cnt = 0;
    int ovf_cnt = 0;

    always @(negedge clk) begin
        if (edge_n > 0) begin
            check("pushin",    int'(bus.Pushin),    exp_push);
            check("firstdata", int'(bus.FirstData), exp_first);
            check("dinr",      int'(bus.DinR),      exp_r);
            check("dini",      int'(bus.DinI),      exp_i);
            check("overflow",  int'(bus.Overflow),  exp_ovf);
            check("stopin",    int'(bus.StopIn),    (q.size() == FIFO_DEPTH) ? 1 : 0);
            if (bus.FirstData === 1'b1) sym_cnt++;
            if (bus.Overflow === 1'b1)  ovf_cnt++;
        end
    end

    task automatic cyc(input bit push, input logic [47:0] d, input bit r);
        bus.PushIn = push;
        bus.DataIn = d;
        rst        = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
    endtask

    int base;
    int obase;
    int burst;
    bit p;
    bit r;

    initial begin
        bus.PushIn = 1'b0;
        bus.DataIn = '0;
        repeat (3) cyc(1'b0, '0, 1'b1);
        check("rst_pushin", int'(bus.Pushin), 0);
        check("rst_first",  int'(bus.FirstData), 0);
        check("rst_dinr",   int'(bus.DinR), 0);
        check("rst_dini",   int'(bus.DinI), 0);
        check("rst_stop",   int'(bus.StopIn), 0);
        check("rst_ovf",    int'(bus.Overflow), 0);

        // Single all-zero word: bin 0 three edges after the push.
        base = sym_cnt;
        cyc(1'b1, 48'h0, 1'b0);
        idle(2);
        check("lat_before", int'(bus.FirstData), 0);
        idle(1);
        check("lat_first", int'(bus.FirstData), 1);
        check("lat_pushin", int'(bus.Pushin), 1);
        idle(140);
        check("sym0_count", sym_cnt - base, 1);

        // Back-to-back symbols.
        base = sym_cnt;
        cyc(1'b1, 48'hFFFF_FFFF_FFFF, 1'b0);
        cyc(1'b1, 48'h5555_5555_5555, 1'b0);
        idle(270);
        check("b2b_count", sym_cnt - base, 2);

        // Overflow while sending.
        cyc(1'b1, 48'h1234_5678_9ABC, 1'b0);
        idle(10);
        base  = sym_cnt;
        obase = ovf_cnt;
        cyc(1'b1, 48'hDEAD_BEEF_0001, 1'b0);
        cyc(1'b1, 48'h0F0F_F0F0_A5A5, 1'b0);
        check("stop_full", int'(bus.StopIn), 1);
        cyc(1'b1, 48'hFFFF_0000_FFFF, 1'b0);
        check("ovf_pulse", int'(bus.Overflow), 1);
        idle(1);
        check("ovf_clear", int'(bus.Overflow), 0);
        idle(400);
        check("ovf_symbols", sym_cnt - base, 2);
        check("ovf_count", ovf_cnt - obase, 1);

        // Single low bit set.
        cyc(1'b1, 48'h0000_0000_0001, 1'b0);
        idle(140);

        // Reset right after bin 60 is emitted, with one word queued.
        cyc(1'b1, 48'hAAAA_5555_AAAA, 1'b0);
        idle(9);
        cyc(1'b1, 48'h1111_2222_3333, 1'b0);
        idle(53);
        check("pre_rst_stream", int'(bus.Pushin), 1);
        cyc(1'b0, '0, 1'b1);
        check("midrst_pushin", int'(bus.Pushin), 0);
        check("midrst_dinr",   int'(bus.DinR), 0);
        check("midrst_dini",   int'(bus.DinI), 0);
        check("midrst_stop",   int'(bus.StopIn), 0);
        base = sym_cnt;
        idle(300);
        check("midrst_nosym", sym_cnt - base, 0);

        // Random traffic with occasional bursts and resets.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(2, 5);
            p = (burst > 0) || ($urandom_range(0, 99) < 3);
            if (burst > 0) burst--;
            r = ($urandom_range(0, 999) == 0);
            cyc(p, {$urandom, $urandom} >> 16, r);
        end
        idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
